// File: rtl/alu_op_sequencer_if.sv
// Bundles the command, response and ALU-facing signals of the ALU operation sequencer.
// slave = sequencer view; master = control unit plus ALU view.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [3:0]       cmd_select;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_carry;
    logic [CNT_W-1:0] cmd_repeat;
    logic             cmd_chain_carry;
    logic             cmd_stop_on_cmp;

    logic             alu_mode;
    logic [3:0]       alu_select;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry_out;
    logic             alu_compare;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_compare;
    logic [CNT_W:0]   rsp_iters;

    modport master (
        output cmd_valid, cmd_mode, cmd_select, cmd_a, cmd_b, cmd_carry,
               cmd_repeat, cmd_chain_carry, cmd_stop_on_cmp,
        input  cmd_ready,
        input  alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in,
        output alu_out, alu_carry_out, alu_compare,
        input  rsp_valid, rsp_data, rsp_carry, rsp_compare, rsp_iters,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_select, cmd_a, cmd_b, cmd_carry,
               cmd_repeat, cmd_chain_carry, cmd_stop_on_cmp,
        output cmd_ready,
        output alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in,
        input  alu_out, alu_carry_out, alu_compare,
        output rsp_valid, rsp_data, rsp_carry, rsp_compare, rsp_iters,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the external combinational ALU: registers the operands,
// optionally iterates with feedback into operand A, and returns the final result.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// EXEC  | one ALU iteration per cycle, result sampled at the closing edge
// RESP  | rsp_valid=1, response held until rsp_ready
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic             mode_q, mode_d;
    logic [3:0]       select_q, select_d;
    logic [WIDTH-1:0] in_a_q, in_a_d;
    logic [WIDTH-1:0] in_b_q, in_b_d;
    logic             carry_in_q, carry_in_d;
    logic             cmd_carry_q, cmd_carry_d;
    logic             chain_q, chain_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W:0]   iter_q, iter_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_compare_q, rsp_compare_d;
    logic [CNT_W:0]   rsp_iters_q, rsp_iters_d;

    logic             terminate;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            select_q      <= '0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            carry_in_q    <= 1'b0;
            cmd_carry_q   <= 1'b0;
            chain_q       <= 1'b0;
            stop_q        <= 1'b0;
            remaining_q   <= '0;
            iter_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_compare_q <= 1'b0;
            rsp_iters_q   <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            select_q      <= select_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            carry_in_q    <= carry_in_d;
            cmd_carry_q   <= cmd_carry_d;
            chain_q       <= chain_d;
            stop_q        <= stop_d;
            remaining_q   <= remaining_d;
            iter_q        <= iter_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_compare_q <= rsp_compare_d;
            rsp_iters_q   <= rsp_iters_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        select_d      = select_q;
        in_a_d        = in_a_q;
        in_b_d        = in_b_q;
        carry_in_d    = carry_in_q;
        cmd_carry_d   = cmd_carry_q;
        chain_d       = chain_q;
        stop_d        = stop_q;
        remaining_d   = remaining_q;
        iter_d        = iter_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_compare_d = rsp_compare_q;
        rsp_iters_d   = rsp_iters_q;

        // Early stop looks at the compare of the iteration currently on the ALU.
        terminate = (remaining_q == '0) || (stop_q && bus.alu_compare);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    mode_d      = bus.cmd_mode;
                    select_d    = bus.cmd_select;
                    in_a_d      = bus.cmd_a;
                    in_b_d      = bus.cmd_b;
                    carry_in_d  = bus.cmd_carry;
                    cmd_carry_d = bus.cmd_carry;
                    chain_d     = bus.cmd_chain_carry;
                    stop_d      = bus.cmd_stop_on_cmp;
                    remaining_d = bus.cmd_repeat;
                    iter_d      = '0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                iter_d = iter_q + 1'b1;
                if (terminate) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = bus.alu_out;
                    rsp_carry_d   = bus.alu_carry_out;
                    rsp_compare_d = bus.alu_compare;
                    rsp_iters_d   = iter_q + 1'b1;
                    state_d       = RESP;
                end else begin
                    in_a_d      = bus.alu_out;
                    carry_in_d  = chain_q ? bus.alu_carry_out : cmd_carry_q;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.alu_mode     = mode_q;
    assign bus.alu_select   = select_q;
    assign bus.alu_in_a     = in_a_q;
    assign bus.alu_in_b     = in_b_q;
    assign bus.alu_carry_in = carry_in_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_compare  = rsp_compare_q;
    assign bus.rsp_iters    = rsp_iters_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU beside the DUT, a transaction-level
// reference model checked every cycle, and directed commands with literal expectations.
module tb_alu_op_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef logic [CNT_W:0] iters_t;
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic             cin;
    } iter_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_acc = 0;
    bit acc_flag = 1'b0;
    logic [WIDTH-1:0] a_log[$];
    logic             c_log[$];

    // Behavioural ALU: {compare, carry_out, result}; compare flags a zero result.
    function automatic logic [WIDTH+1:0] alu_f(input logic mode, input logic [3:0] sel,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
        logic [WIDTH:0] s;
        s = '0;
        if (!mode) begin
            case (sel)
                4'b1001: s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                4'b0110: s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                default: s = {1'b0, a} + {{WIDTH{1'b0}}, cin};
            endcase
        end else begin
            case (sel)
                4'b0110: s = {1'b0, a ^ b};
                4'b1011: s = {1'b0, a & b};
                4'b1110: s = {1'b0, a | b};
                default: s = {1'b0, ~a};
            endcase
        end
        return {(s[WIDTH-1:0] == '0), s};
    endfunction

    always_comb begin
        {bus.alu_compare, bus.alu_carry_out, bus.alu_out} =
            alu_f(bus.alu_mode, bus.alu_select, bus.alu_in_a, bus.alu_in_b, bus.alu_carry_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a command is expanded into its list of iterations up front.
    iter_t            m_q[$];
    logic             m_rsp_valid = 1'b0;
    logic [WIDTH-1:0] m_rsp_data = '0;
    logic             m_rsp_carry = 1'b0;
    logic             m_rsp_cmp = 1'b0;
    iters_t           m_rsp_iters = '0;
    logic             m_mode = 1'b0;
    logic [3:0]       m_sel = '0;
    logic [WIDTH-1:0] m_alu_a = '0;
    logic [WIDTH-1:0] m_alu_b = '0;
    logic             m_cin = 1'b0;
    logic [WIDTH-1:0] f_data;
    logic             f_carry;
    logic             f_cmp;
    iters_t           f_iters;

    task automatic plan_cmd();
        logic [WIDTH-1:0] a;
        logic             cin;
        logic [WIDTH+1:0] r;
        iter_t            it;
        int               n;
        a = bus.cmd_a;
        cin = bus.cmd_carry;
        m_q.delete();
        n = int'(bus.cmd_repeat) + 1;
        for (int i = 0; i < n; i++) begin
            it.a = a;
            it.cin = cin;
            m_q.push_back(it);
            r = alu_f(bus.cmd_mode, bus.cmd_select, a, bus.cmd_b, cin);
            f_data = r[WIDTH-1:0];
            f_carry = r[WIDTH];
            f_cmp = r[WIDTH+1];
            f_iters = iters_t'(i + 1);
            if (bus.cmd_stop_on_cmp && f_cmp) break;
            a = f_data;
            cin = bus.cmd_chain_carry ? f_carry : bus.cmd_carry;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        acc_flag = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_rsp_valid = 1'b0;
            m_rsp_data = '0;
            m_rsp_carry = 1'b0;
            m_rsp_cmp = 1'b0;
            m_rsp_iters = '0;
            m_mode = 1'b0;
            m_sel = '0;
            m_alu_a = '0;
            m_alu_b = '0;
            m_cin = 1'b0;
        end else if (m_rsp_valid) begin
            if (bus.rsp_ready) m_rsp_valid = 1'b0;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_data = f_data;
                m_rsp_carry = f_carry;
                m_rsp_cmp = f_cmp;
                m_rsp_iters = f_iters;
            end else begin
                m_alu_a = m_q[0].a;
                m_cin = m_q[0].cin;
            end
        end else if (bus.cmd_valid) begin
            plan_cmd();
            m_mode = bus.cmd_mode;
            m_sel = bus.cmd_select;
            m_alu_b = bus.cmd_b;
            m_alu_a = m_q[0].a;
            m_cin = m_q[0].cin;
            acc_flag = 1'b1;
            t_acc = cyc;
        end
        #1;
        check("cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() == 0 && !m_rsp_valid));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
        check("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
        check("rsp_carry", 32'(bus.rsp_carry), 32'(m_rsp_carry));
        check("rsp_compare", 32'(bus.rsp_compare), 32'(m_rsp_cmp));
        check("rsp_iters", 32'(bus.rsp_iters), 32'(m_rsp_iters));
        check("alu_mode", 32'(bus.alu_mode), 32'(m_mode));
        check("alu_select", 32'(bus.alu_select), 32'(m_sel));
        check("alu_in_a", 32'(bus.alu_in_a), 32'(m_alu_a));
        check("alu_in_b", 32'(bus.alu_in_b), 32'(m_alu_b));
        check("alu_carry_in", 32'(bus.alu_carry_in), 32'(m_cin));
    end

    task automatic send(input logic mode, input logic [3:0] sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin, input logic [CNT_W-1:0] rep,
                        input logic chain, input logic stop);
        @(negedge clk);
        bus.cmd_mode = mode;
        bus.cmd_select = sel;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_carry = cin;
        bus.cmd_repeat = rep;
        bus.cmd_chain_carry = chain;
        bus.cmd_stop_on_cmp = stop;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        check("cmd_accepted", 32'(bus.cmd_ready == 1'b0 && acc_flag), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Logs the ALU operand per EXEC cycle until rsp_valid shows, bounded.
    task automatic wait_rsp(output int lat);
        int guard;
        a_log.delete();
        c_log.delete();
        guard = 0;
        lat = -1;
        while (guard < 40) begin
            if (bus.rsp_valid === 1'b1) begin
                lat = cyc - t_acc;
                break;
            end
            a_log.push_back(bus.alu_in_a);
            c_log.push_back(bus.alu_carry_in);
            @(negedge clk);
            guard++;
        end
        if (lat < 0) check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
    endtask

    int lat;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_mode = 1'b0;
        bus.cmd_select = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_carry = 1'b0;
        bus.cmd_repeat = '0;
        bus.cmd_chain_carry = 1'b0;
        bus.cmd_stop_on_cmp = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_in_a", 32'(bus.alu_in_a), 32'd0);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // single add 3+4
        send(1'b0, 4'b1001, 16'd3, 16'd4, 1'b0, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t1_latency", 32'(lat), 32'd1);
        check("t1_data", 32'(bus.rsp_data), 32'd7);
        check("t1_iters", 32'(bus.rsp_iters), 32'd1);
        check("t1_carry", 32'(bus.rsp_carry), 32'd0);
        @(negedge clk);

        // iterated add, A follows 1,2,3,4
        send(1'b0, 4'b1001, 16'd1, 16'd1, 1'b0, 4'd3, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_a_count", 32'(a_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < a_log.size()) check("t2_a_seq", 32'(a_log[i]), 32'(i + 1));
        check("t2_data", 32'(bus.rsp_data), 32'd5);
        check("t2_iters", 32'(bus.rsp_iters), 32'd4);
        @(negedge clk);

        // wrap with carry chain: FFFF+1 -> 0000 c=1, then 0+1+1 -> 2
        send(1'b0, 4'b1001, 16'hFFFF, 16'd1, 1'b0, 4'd1, 1'b1, 1'b0);
        wait_rsp(lat);
        if (c_log.size() == 2) begin
            check("t3_cin_iter2", 32'(c_log[1]), 32'd1);
            check("t3_a_iter2", 32'(a_log[1]), 32'd0);
        end else check("t3_iter_count", 32'(c_log.size()), 32'd2);
        check("t3_data", 32'(bus.rsp_data), 32'd2);
        check("t3_carry", 32'(bus.rsp_carry), 32'd0);
        check("t3_iters", 32'(bus.rsp_iters), 32'd2);
        @(negedge clk);

        // early stop: FFFD+1 reaches zero on iteration 3
        send(1'b0, 4'b1001, 16'hFFFD, 16'd1, 1'b0, 4'd15, 1'b0, 1'b1);
        wait_rsp(lat);
        check("t4_latency", 32'(lat), 32'd3);
        check("t4_iters", 32'(bus.rsp_iters), 32'd3);
        check("t4_compare", 32'(bus.rsp_compare), 32'd1);
        check("t4_data", 32'(bus.rsp_data), 32'd0);
        check("t4_carry", 32'(bus.rsp_carry), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_a_held", 32'(bus.alu_in_a), 32'hFFFF);

        // early stop on the first iteration: FFFF+1 is zero immediately
        send(1'b0, 4'b1001, 16'hFFFF, 16'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        wait_rsp(lat);
        check("t4b_iters", 32'(bus.rsp_iters), 32'd1);
        @(negedge clk);

        // subtract with constant carry: 10-3 three times -> 1
        send(1'b0, 4'b0110, 16'd10, 16'd3, 1'b1, 4'd2, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t5_data", 32'(bus.rsp_data), 32'd1);
        check("t5_carry", 32'(bus.rsp_carry), 32'd1);
        check("t5_iters", 32'(bus.rsp_iters), 32'd3);
        @(negedge clk);

        // logic xor iterated three times
        send(1'b1, 4'b0110, 16'h00FF, 16'h0F0F, 1'b0, 4'd2, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t6_data", 32'(bus.rsp_data), 32'h0FF0);
        check("t6_iters", 32'(bus.rsp_iters), 32'd3);
        @(negedge clk);

        // maximum iteration count
        send(1'b0, 4'b1001, 16'd0, 16'd1, 1'b0, 4'd15, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t7_latency", 32'(lat), 32'd16);
        check("t7_iters", 32'(bus.rsp_iters), 32'd16);
        check("t7_data", 32'(bus.rsp_data), 32'd16);
        @(negedge clk);

        // backpressure with an ignored command
        bus.rsp_ready = 1'b0;
        send(1'b0, 4'b1001, 16'd3, 16'd4, 1'b0, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        bus.cmd_a = 16'h1234;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t8_hold_data", 32'(bus.rsp_data), 32'd7);
            check("t8_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t8_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t8_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("t8_data_kept", 32'(bus.rsp_data), 32'd7);
        check("t8_idle", 32'(bus.cmd_ready), 32'd1);

        // reset in the middle of a long command
        send(1'b1, 4'b1110, 16'h0101, 16'h0010, 1'b1, 4'd15, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t9_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t9_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t9_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("t9_rsp_iters", 32'(bus.rsp_iters), 32'd0);
        check("t9_alu_in_a", 32'(bus.alu_in_a), 32'd0);
        check("t9_alu_in_b", 32'(bus.alu_in_b), 32'd0);
        check("t9_alu_mode", 32'(bus.alu_mode), 32'd0);
        check("t9_alu_cin", 32'(bus.alu_carry_in), 32'd0);
        rst_n = 1'b1;

        send(1'b0, 4'b1001, 16'd3, 16'd4, 1'b0, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        check("t10_data", 32'(bus.rsp_data), 32'd7);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
